// File: rtl/bcd_display_unit.sv
// Captures a selected operand, converts it to BCD one bit per clock (shift-add-3) and drives seven-segment digits plus a sign slice.
// Optional leading-zero blanking with a floating minus sign is enabled by defining BCD_DISPLAY_LZB_EN.
module bcd_display_unit #(
    parameter int WIDTH          = 16,
    parameter int DIGITS         = 5,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                      CLK,
    input  logic                      CLR,
    input  logic                      IUAU,
    input  logic [WIDTH-1:0]          In,
    input  logic [WIDTH-1:0]          Result,
    input  logic                      SIGNED,
    input  logic                      LoadOU,
    output logic                      BUSY,
    output logic                      DONE,
    output logic [7*(DIGITS+1)-1:0]   SEG
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [6:0] G_MINUS = 7'b1111110;
    localparam logic [6:0] G_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_UPDATE
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [WIDTH-1:0]       shift_q;
    logic [4*DIGITS-1:0]    bcd_q;
    logic                   neg_q;
    logic [CW-1:0]          cnt_q;
    logic [4*DIGITS-1:0]    disp_q;
    logic                   sign_q;
    logic                   busy_q;
    logic                   done_q;

    logic [WIDTH-1:0]       src;
    logic                   neg;
    logic [WIDTH-1:0]       mag;
    logic [4*DIGITS-1:0]    bcd_adj;
    logic [4*DIGITS-1:0]    bcd_nxt;
    logic [WIDTH-1:0]       shift_nxt;

    logic [DIGITS-1:0]      shown;
    logic [DIGITS-1:0]      lower_shown;
    logic                   any_nz;
    logic [7*(DIGITS+1)-1:0] seg_al;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 7'b0000001;
            4'd1:    glyph = 7'b1001111;
            4'd2:    glyph = 7'b0010010;
            4'd3:    glyph = 7'b0000110;
            4'd4:    glyph = 7'b1001100;
            4'd5:    glyph = 7'b0100100;
            4'd6:    glyph = 7'b0100000;
            4'd7:    glyph = 7'b0001111;
            4'd8:    glyph = 7'b0000000;
            4'd9:    glyph = 7'b0000100;
            default: glyph = 7'b1111111;
        endcase
    endfunction

    assign src = IUAU ? Result : In;
    assign neg = SIGNED & src[WIDTH-1];
    // The most negative value negates to itself, which is the correct unsigned magnitude.
    assign mag = neg ? ((~src) + WIDTH'(1)) : src;

    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
            end
        end
    end

    assign bcd_nxt   = {bcd_adj[4*DIGITS-2:0], shift_q[WIDTH-1]};
    assign shift_nxt = {shift_q[WIDTH-2:0], 1'b0};

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (LoadOU) state_d = ST_CONV;
            ST_CONV:   if (cnt_q == '0) state_d = ST_UPDATE;
            ST_UPDATE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs are registered, so they trail the state by one edge.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            shift_q <= '0;
            bcd_q   <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            disp_q  <= '0;
            sign_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            busy_q <= (state_q == ST_CONV);
            done_q <= (state_q == ST_UPDATE);
            case (state_q)
                ST_IDLE: begin
                    if (LoadOU) begin
                        shift_q <= mag;
                        bcd_q   <= '0;
                        neg_q   <= neg;
                        cnt_q   <= CW'(WIDTH - 1);
                    end
                end
                ST_CONV: begin
                    shift_q <= shift_nxt;
                    bcd_q   <= bcd_nxt;
                    cnt_q   <= cnt_q - CW'(1);
                end
                ST_UPDATE: begin
                    disp_q <= bcd_q;
                    sign_q <= neg_q;
                end
                default: ;
            endcase
        end
    end

    assign BUSY = busy_q;
    assign DONE = done_q;

`ifdef BCD_DISPLAY_LZB_EN
    always_comb begin
        any_nz = 1'b0;
        shown  = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            any_nz   = any_nz | (disp_q[4*k +: 4] != 4'd0);
            shown[k] = any_nz | (k == 0);
        end
    end
`else
    always_comb begin
        any_nz = 1'b0;
        shown  = '1;
    end
`endif

    // Minus sits in the first blank slice directly above the top shown digit.
    assign lower_shown = {shown[DIGITS-2:0], 1'b0};

    always_comb begin
        seg_al = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (shown[k]) begin
                seg_al[7*k +: 7] = glyph(disp_q[4*k +: 4]);
            end else if (sign_q && lower_shown[k]) begin
                seg_al[7*k +: 7] = G_MINUS;
            end else begin
                seg_al[7*k +: 7] = G_BLANK;
            end
        end
        seg_al[7*DIGITS +: 7] = (sign_q && shown[DIGITS-1]) ? G_MINUS : G_BLANK;
    end

    assign SEG = SEG_ACTIVE_LOW ? seg_al : ~seg_al;

endmodule

// File: tb/tb_bcd_display_unit.sv
// Randomised and directed bench for bcd_display_unit; expected glyphs come from decimal arithmetic on the loaded value.
module tb_bcd_display_unit;

    localparam int W  = 16;
    localparam int D  = 5;
    localparam int SW = 7 * (D + 1);

    logic          clk = 1'b0;
    logic          clr;
    logic          iuau;
    logic [W-1:0]  in_v;
    logic [W-1:0]  res;
    logic          sgn;
    logic          load;
    logic          busy;
    logic          done;
    logic [SW-1:0] seg;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [SW-1:0] disp_exp;

    bcd_display_unit #(
        .WIDTH(W),
        .DIGITS(D),
        .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .CLK(clk),
        .CLR(clr),
        .IUAU(iuau),
        .In(in_v),
        .Result(res),
        .SIGNED(sgn),
        .LoadOU(load),
        .BUSY(busy),
        .DONE(done),
        .SEG(seg)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [SW-1:0] model_seg(input int unsigned mag, input bit neg);
        int            n;
        int unsigned   t;
        int unsigned   p;
        logic [SW-1:0] s;
        s = '0;
`ifdef BCD_DISPLAY_LZB_EN
        n = 1;
        t = mag / 10;
        while (t != 0) begin
            n++;
            t = t / 10;
        end
`else
        t = 0;
        n = D;
`endif
        p = 1;
        for (int k = 0; k <= D; k++) begin
            if (k < n)                s[7*k +: 7] = glyph(int'((mag / p) % 10));
            else if (neg && k == n)   s[7*k +: 7] = 7'b1111110;
            else                      s[7*k +: 7] = 7'b1111111;
            p = p * 10;
        end
        return s;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_conv(input string name, input bit iu, input logic [W-1:0] a,
                            input logic [W-1:0] r, input bit s, input int poke_at);
        logic [W-1:0]  src;
        bit            neg;
        int unsigned   mag;
        logic [SW-1:0] new_seg;
        logic [SW-1:0] exp_seg;
        bit            exp_busy;
        bit            exp_done;
        src     = iu ? r : a;
        neg     = s && src[W-1];
        mag     = neg ? (32'd65536 - 32'(src)) : 32'(src);
        new_seg = model_seg(mag, neg);
        iuau = iu; in_v = a; res = r; sgn = s; load = 1'b1;
        tick;
        load = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            if (k == poke_at) begin
                load = 1'b1; in_v = 16'd42; iuau = 1'b0; sgn = 1'b0;
            end
            tick;
            load     = 1'b0;
            exp_busy = (k <= 16);
            exp_done = (k == 17);
            exp_seg  = (k >= 17) ? new_seg : disp_exp;
            n_checks++;
            if (busy !== exp_busy || done !== exp_done) begin
                n_errors++;
                $display("FAIL %s handshake +%0d: busy=%b done=%b, expected busy=%b done=%b",
                         name, k, busy, done, exp_busy, exp_done);
            end
            n_checks++;
            if (seg !== exp_seg) begin
                n_errors++;
                $display("FAIL %s seg +%0d: got %h, expected %h", name, k, seg, exp_seg);
            end
        end
        disp_exp = new_seg;
        if (poke_at != 0) begin
            for (int k = 0; k < 20; k++) begin
                tick;
                n_checks++;
                if (done !== 1'b0 || seg !== disp_exp) begin
                    n_errors++;
                    $display("FAIL %s ignored-load idle %0d: done=%b seg=%h, expected done=0 seg=%h",
                             name, k, done, seg, disp_exp);
                end
            end
        end
    endtask

    task automatic test_reset;
        clr = 1'b1; iuau = 1'b0; in_v = '0; res = '0; sgn = 1'b0; load = 1'b0;
        disp_exp = model_seg(0, 1'b0);
        repeat (3) tick;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || seg !== disp_exp) begin
            n_errors++;
            $display("FAIL reset_hold: busy=%b done=%b seg=%h, expected 0 0 %h", busy, done, seg, disp_exp);
        end
        @(negedge clk);
        clr = 1'b0;
        repeat (3) tick;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || seg !== disp_exp) begin
            n_errors++;
            $display("FAIL reset_release: busy=%b done=%b seg=%h, expected 0 0 %h", busy, done, seg, disp_exp);
        end
    endtask

    task automatic test_directed;
        run_conv("u12345",   1'b0, 16'd12345, 16'h0000, 1'b0, 0);
        run_conv("s8000",    1'b1, 16'h0000,  16'h8000, 1'b1, 0);
        run_conv("sFFFF",    1'b1, 16'h0000,  16'hFFFF, 1'b1, 0);
        run_conv("uFFFF",    1'b1, 16'h0000,  16'hFFFF, 1'b0, 0);
        run_conv("sFFF6",    1'b1, 16'h1234,  16'hFFF6, 1'b1, 0);
        run_conv("zero",     1'b0, 16'd0,     16'hFFFF, 1'b1, 0);
        run_conv("s_pos",    1'b0, 16'd700,   16'h8000, 1'b1, 0);
    endtask

    task automatic test_ignore_while_busy;
        run_conv("busy_poke",   1'b0, 16'd999,   16'd0, 1'b0, 5);
        run_conv("update_poke", 1'b0, 16'd31415, 16'd0, 1'b0, 17);
    endtask

    task automatic test_clear_mid;
        iuau = 1'b0; in_v = 16'd65535; sgn = 1'b0; load = 1'b1;
        tick;
        load = 1'b0;
        repeat (7) tick;
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++;
            $display("FAIL clr_mid busy_before: busy=%b, expected 1", busy);
        end
        @(posedge clk);
        #2;
        clr = 1'b1;
        #1;
        disp_exp = model_seg(0, 1'b0);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || seg !== disp_exp) begin
            n_errors++;
            $display("FAIL clr_mid async: busy=%b done=%b seg=%h, expected 0 0 %h", busy, done, seg, disp_exp);
        end
        @(negedge clk);
        clr = 1'b0;
        for (int k = 0; k < 25; k++) begin
            tick;
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0 || seg !== disp_exp) begin
                n_errors++;
                $display("FAIL clr_mid quiet %0d: busy=%b done=%b seg=%h, expected 0 0 %h",
                         k, busy, done, seg, disp_exp);
            end
        end
        run_conv("after_clr", 1'b0, 16'd7, 16'd0, 1'b0, 0);
    endtask

    task automatic test_back_to_back;
        logic [SW-1:0] seg_a;
        logic [SW-1:0] seg_b;
        logic [SW-1:0] exp_seg;
        bit            exp_busy;
        bit            exp_done;
        seg_a = model_seg(2468, 1'b0);
        seg_b = model_seg(50001, 1'b0);
        iuau = 1'b0; sgn = 1'b0; in_v = 16'd2468; load = 1'b1;
        tick;
        in_v = 16'd50001;
        for (int k = 1; k <= 35; k++) begin
            tick;
            if (k == 35) load = 1'b0;
            exp_done = (k == 17) || (k == 35);
            exp_busy = (k >= 1 && k <= 16) || (k >= 19 && k <= 34);
            exp_seg  = (k >= 35) ? seg_b : ((k >= 17) ? seg_a : disp_exp);
            n_checks++;
            if (busy !== exp_busy || done !== exp_done || seg !== exp_seg) begin
                n_errors++;
                $display("FAIL b2b +%0d: busy=%b done=%b seg=%h, expected %b %b %h",
                         k, busy, done, seg, exp_busy, exp_done, exp_seg);
            end
        end
        disp_exp = seg_b;
        repeat (3) tick;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b tail: busy=%b done=%b, expected 0 0", busy, done);
        end
    endtask

    task automatic test_random;
        logic [W-1:0] a;
        logic [W-1:0] r;
        for (int i = 0; i < 25; i++) begin
            a = W'($urandom_range(0, 65535));
            r = W'($urandom_range(0, 65535));
            if (i % 5 == 0) r = W'($urandom_range(0, 9)) | 16'hFFF0;
            run_conv("random", 1'($urandom_range(0, 1)), a, r, 1'($urandom_range(0, 1)), 0);
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_ignore_while_busy;
        test_clear_mid;
        test_back_to_back;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bcd_display_unit.md
Name: bcd_display_unit

Overview:
- Parametrised, sequential successor to the calculator output unit.
- Selects the operand-entry value or the ALU result and captures it on a load strobe.
- Converts the captured value to BCD with an iterative shift-add-3 (double-dabble) engine, one bit per clock, instead of a combinational converter.
- Drives DIGITS magnitude seven-segment displays plus one sign display, with a busy/done handshake to the control unit.

Parameters:
- WIDTH, 16, bit width of both data inputs; legal 4..32.
- DIGITS, 5, number of decimal magnitude digits; must satisfy 10^DIGITS > 2^WIDTH - 1.
- SEG_ACTIVE_LOW, 1, 1 = segment lit when bit is 0 (board default); 0 = lit when bit is 1.

Ports:
- CLK  input  1  system clock, rising edge.
- CLR  input  1  asynchronous, active-high reset.
- IUAU  input  1  source select: 0 = In, 1 = Result.
- In  input  WIDTH  operand-entry value.
- Result  input  WIDTH  ALU result.
- SIGNED  input  1  1 = treat the selected source as two's complement.
- LoadOU  input  1  load strobe, sampled each clock edge.
- BUSY  output  1  conversion in progress.
- DONE  output  1  one-cycle pulse when the display registers update.
- SEG  output  7*(DIGITS+1)  slice k = SEG[7k+6:7k]; k=0 is the ones digit, k=DIGITS is the sign; within a slice bit 6 = a ... bit 0 = g.

Behaviour:
- Reset (CLR high, asynchronous): state IDLE; BUSY=0; DONE=0; capture, shift and BCD registers = 0; display BCD = all 0; sign = off. SEG then shows "0" on every digit and blank on the sign digit.
- State IDLE: LoadOU=1 at edge N captures the source selected by IUAU.
  - neg = SIGNED & src[WIDTH-1].
  - mag = neg ? (~src + 1) mod 2^WIDTH : src.
  - Transition to CONV; BUSY=1 from cycle N+1.
- State CONV: WIDTH cycles. Each cycle, every BCD nibble >= 5 gets +3, then {bcd, mag} shifts left by 1. Bit counter runs WIDTH-1 down to 0.
- State UPDATE: display BCD and sign registers load from the working registers. DONE=1 for exactly this cycle. BUSY=0. Next state IDLE.
- Latency: the display changes and DONE pulses at edge N+WIDTH+1 (17 cycles for WIDTH=16). SEG is purely combinational from the display registers.
- LoadOU while BUSY=1 is ignored and not queued. LoadOU held high re-triggers on the first IDLE cycle after UPDATE.
- LoadOU in the UPDATE cycle is ignored.
- Display registers hold the old value for the whole conversion; there is no partial update.
- Most negative value (src = 2^(WIDTH-1), SIGNED=1): mag = 2^(WIDTH-1) as unsigned, which is correct; sign lit.
- neg=1 with mag=0 cannot occur. Sign is off whenever SIGNED=0.
- CLR asserted mid-conversion: immediate return to reset values; the in-flight conversion is discarded and DONE never fires.
- Glyphs, written with SEG_ACTIVE_LOW=1 (invert all for 0):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - minus = 1111110, blank = 1111111.
- Sign slice shows minus when neg=1, blank otherwise.

Optional Feature:
- Macro: BCD_DISPLAY_LZB_EN.
- Defined: leading-zero blanking. Magnitude digit k is blank when it and all higher digits are 0, except digit 0, which always shows. The minus glyph moves to the slice directly left of the most-significant shown digit; the sign slice k=DIGITS shows minus only when all DIGITS digits are significant, and is blank otherwise.
- Undefined: every digit always shows, including leading zeros, and minus appears only in slice DIGITS.
- Handshake and latency are identical in both builds.

Test Plan (WIDTH=16, DIGITS=5, SEG_ACTIVE_LOW=1, macro undefined unless noted):
- Reset, then release CLR without loading -> BUSY=0, DONE=0, slices 0..4 = 0000001, slice 5 = 1111111.
- IUAU=0, In=12345, SIGNED=0, one-cycle LoadOU at edge N -> BUSY 1 for N+1..N+16, DONE only at N+17, digits 1,2,3,4,5, sign blank.
- IUAU=1, Result=16'h8000, SIGNED=1 -> digits 3,2,7,6,8, slice 5 = minus. Result=16'hFFFF, SIGNED=1 -> 00001 with minus. Same with SIGNED=0 -> 65535, sign blank.
- Load 999, then pulse LoadOU with In=42 at N+5 -> the second load is ignored; display 00999 at N+17, then no further DONE.
- Load 65535, assert CLR at N+8 -> display returns to 00000 immediately, DONE never pulses; a fresh load of 7 afterwards completes normally.
- Macro defined, Result=16'hFFF6 (-10), SIGNED=1 -> slices 0,1 = 0,1; slice 2 = minus; slices 3,4,5 blank. Load 0 -> only slice 0 shows "0".
